instruction_fetch: RTL and testbench

INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

---
 rtl/macpu_pkg.sv | 18 +
 rtl/fetch_queue.sv | 56 +++++
 rtl/instruction_fetch.sv | 103 ++++++++++
 tb/tb_instruction_fetch.sv | 408 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/macpu_pkg.sv
// Shared CPU definitions: bus widths, fetch FSM states and the prefetch queue entry.
package macpu_pkg;

  localparam int ADDR_W = 16;
  localparam int DATA_W = 16;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    DISCARD
  } fetch_state_t;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// Synchronous prefetch FIFO holding {address, instruction} pairs; flush empties it in one edge.
module fetch_queue
  import macpu_pkg::*;
#(
  parameter  int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic         clk,
  input  logic         n_rst,
  input  logic         push,
  input  fetch_entry_t push_entry,
  input  logic         pop,
  input  logic         flush,
  output fetch_entry_t head,
  output logic         full,
  output logic         empty,
  output logic [PTR_W:0] count
);

  fetch_entry_t     mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == (PTR_W + 1)'(DEPTH));
  // A pop on empty is ignored; a push into a full queue only lands if a pop frees the slot.
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + {{PTR_W{1'b0}}, do_push} - {{PTR_W{1'b0}}, do_pop};
    end
  end

  // NOTE: storage is not reset; the head is masked to zero whenever the queue is empty instead.
  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr] <= push_entry;
  end

  assign head = empty ? '0 : mem[rd_ptr];

endmodule

// File: rtl/instruction_fetch.sv
// Instruction fetch: single-outstanding memory read FSM, PC hold handshake, prefetch queue.
module instruction_fetch
  import macpu_pkg::*;
#(
  parameter int QDEPTH = 4
) (
  input  logic              clk,
  input  logic              n_rst,
  input  logic [ADDR_W-1:0] i_pc_address,
  output logic              o_pc_lock,
  output logic              o_pc_address_en,
  input  logic              i_flush,
  output logic              o_mem_req,
  output logic [ADDR_W-1:0] o_mem_addr,
  input  logic              i_mem_ack,
  input  logic [DATA_W-1:0] i_mem_data,
  output logic              o_instr_valid,
  output logic [DATA_W-1:0] o_instr,
  output logic [ADDR_W-1:0] o_instr_addr,
  input  logic              i_instr_ready
);

  localparam int CNT_W = $clog2(QDEPTH) + 1;

  fetch_state_t     state;
  fetch_state_t     state_nxt;
  logic             armed;
  logic             launch;
  logic             push;
  logic             pop;
  logic             q_full;
  logic             q_empty;
  logic [CNT_W-1:0] q_count;
  fetch_entry_t     head;

  // armed delays the first request to the second edge after reset release.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state      <= IDLE;
      armed      <= 1'b0;
      o_mem_addr <= '0;
    end else begin
      state <= state_nxt;
      armed <= 1'b1;
      if (launch) o_mem_addr <= i_pc_address;
    end
  end

  // An ack always returns to IDLE: the PC advances on the ack edge, so the
  // following IDLE cycle is where the incremented address gets latched.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path can infer a latch.
    state_nxt = state;
    launch    = 1'b0;
    push      = 1'b0;
    unique case (state)
      IDLE: begin
        if (armed && !i_flush && !q_full) begin
          state_nxt = REQ;
          launch    = 1'b1;
        end
      end
      REQ: begin
        if (i_mem_ack) begin
          push      = !i_flush;
          state_nxt = IDLE;
        end else if (i_flush) begin
          state_nxt = DISCARD;
        end
      end
      DISCARD: begin
        if (i_mem_ack) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign o_mem_req       = (state != IDLE);
  assign o_pc_lock       = ~push;
  assign o_pc_address_en = n_rst & (state != DISCARD);
  assign o_instr_valid   = ~q_empty;
  assign o_instr         = head.data;
  assign o_instr_addr    = head.addr;
  assign pop             = o_instr_valid & i_instr_ready;

  fetch_queue #(
    .DEPTH(QDEPTH)
  ) u_queue (
    .clk       (clk),
    .n_rst     (n_rst),
    .push      (push),
    .push_entry('{addr: o_mem_addr, data: i_mem_data}),
    .pop       (pop),
    .flush     (i_flush),
    .head      (head),
    .full      (q_full),
    .empty     (q_empty),
    .count     (q_count)
  );

  a_no_overflow : assert property (@(posedge clk) disable iff (!n_rst) q_count <= CNT_W'(QDEPTH));

endmodule

// File: tb/tb_instruction_fetch.sv
// Randomised bench for instruction_fetch: bench acts as PC and memory, scoreboard models the queue.
module tb_instruction_fetch;
  import macpu_pkg::*;

  localparam int QDEPTH = 4;

  logic        clk = 1'b0;
  logic        n_rst = 1'b1;
  logic [15:0] i_pc_address = '0;
  logic        o_pc_lock;
  logic        o_pc_address_en;
  logic        i_flush = 1'b0;
  logic        o_mem_req;
  logic [15:0] o_mem_addr;
  logic        i_mem_ack = 1'b0;
  logic [15:0] i_mem_data = '0;
  logic        o_instr_valid;
  logic [15:0] o_instr;
  logic [15:0] o_instr_addr;
  logic        i_instr_ready = 1'b0;

  instruction_fetch #(.QDEPTH(QDEPTH)) dut (
    .clk            (clk),
    .n_rst          (n_rst),
    .i_pc_address   (i_pc_address),
    .o_pc_lock      (o_pc_lock),
    .o_pc_address_en(o_pc_address_en),
    .i_flush        (i_flush),
    .o_mem_req      (o_mem_req),
    .o_mem_addr     (o_mem_addr),
    .i_mem_ack      (i_mem_ack),
    .i_mem_data     (i_mem_data),
    .o_instr_valid  (o_instr_valid),
    .o_instr        (o_instr),
    .o_instr_addr   (o_instr_addr),
    .i_instr_ready  (i_instr_ready)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] addr;
    logic [15:0] data;
  } word_t;

  int          vectors = 0;
  int          miscompares = 0;
  word_t       q[$];
  logic [15:0] popped[$];
  logic [15:0] req_addrs[$];
  logic [15:0] pc = '0;
  logic [15:0] salt;
  logic [15:0] req_addr = '0;
  int          ack_delay = 1;
  int          wait_cnt = 0;
  bit          rand_delay = 0;
  bit          discarding = 0;
  bit          prev_req = 0;
  bit          rose = 0;
  bit          ready_rand = 0;
  bit          ready_val = 1;
  logic        last_lock;

  function automatic logic [15:0] memfn(input logic [15:0] a);
    return (a * 16'h9E37) ^ salt;
  endfunction

  // One clock: drive PC/memory/decoder at negedge, score outputs, advance the model at posedge.
  task automatic tick(input bit flush = 1'b0, input logic [15:0] new_pc = 16'h0000);
    bit accepted;
    bit popping;
    @(negedge clk);
    i_pc_address  = pc;
    i_flush       = flush;
    i_instr_ready = ready_rand ? 1'($urandom_range(0, 1)) : ready_val;
    i_mem_ack     = 1'b0;
    rose          = 1'b0;
    if (o_mem_req) begin
      if (!prev_req) begin
        rose = 1'b1;
        req_addr = o_mem_addr;
        req_addrs.push_back(o_mem_addr);
        if (rand_delay) ack_delay = $urandom_range(0, 3);
        vectors++;
        if (o_mem_addr !== pc)
          $display("FAIL req_addr: got %h expected %h at %0t", o_mem_addr, pc, $time);
        if (o_mem_addr !== pc) miscompares++;
      end else begin
        vectors++;
        if (o_mem_addr !== req_addr) begin
          miscompares++;
          $display("FAIL addr_stable: got %h expected %h at %0t", o_mem_addr, req_addr, $time);
        end
      end
      if (wait_cnt >= ack_delay) begin
        i_mem_ack = 1'b1;
        wait_cnt  = 0;
      end else begin
        wait_cnt++;
      end
    end
    i_mem_data = i_mem_ack ? memfn(o_mem_addr) : 16'($urandom);
    prev_req   = o_mem_req;
    #1;
    accepted  = o_mem_req && i_mem_ack && !flush && !discarding;
    last_lock = o_pc_lock;
    vectors++;
    if (o_pc_lock !== !accepted) begin
      miscompares++;
      $display("FAIL pc_lock: got %b expected %b at %0t", o_pc_lock, !accepted, $time);
    end
    vectors++;
    if (o_pc_address_en !== !discarding) begin
      miscompares++;
      $display("FAIL pc_address_en: got %b expected %b at %0t", o_pc_address_en, !discarding, $time);
    end
    vectors++;
    if (o_instr_valid !== (q.size() != 0)) begin
      miscompares++;
      $display("FAIL instr_valid: got %b expected %b at %0t", o_instr_valid, q.size() != 0, $time);
    end
    if (q.size() != 0) begin
      vectors++;
      if (o_instr_addr !== q[0].addr || o_instr !== q[0].data) begin
        miscompares++;
        $display("FAIL head: got %h/%h expected %h/%h at %0t",
                 o_instr_addr, o_instr, q[0].addr, q[0].data, $time);
      end
    end
    popping = i_instr_ready && (q.size() != 0) && !flush;
    if (popping) popped.push_back(o_instr_addr);
    @(posedge clk);
    if (o_mem_req && i_mem_ack) discarding = 1'b0;
    else if (flush && o_mem_req) discarding = 1'b1;
    if (flush) begin
      q.delete();
    end else begin
      if (popping) void'(q.pop_front());
      if (accepted) q.push_back('{pc, memfn(pc)});
    end
    if (accepted) pc = pc + 16'h1;
    if (flush) pc = new_pc;
    vectors++;
    if (q.size() > QDEPTH) begin
      miscompares++;
      $display("FAIL overflow: got %0d entries expected at most %0d", q.size(), QDEPTH);
    end
  endtask

  task automatic clear_model(input logic [15:0] start_pc);
    pc = start_pc;
    i_pc_address = start_pc;
    q.delete();
    popped.delete();
    req_addrs.delete();
    discarding = 0;
    prev_req = 0;
    wait_cnt = 0;
  endtask

  task automatic do_reset(input logic [15:0] start_pc);
    @(negedge clk);
    n_rst = 1'b0;
    i_mem_ack = 1'b0;
    i_flush = 1'b0;
    @(negedge clk);
    n_rst = 1'b1;
    clear_model(start_pc);
  endtask

  task automatic check_reset_outputs(input string tag);
    vectors++;
    if (o_mem_req !== 1'b0 || o_mem_addr !== 16'h0 || o_instr_valid !== 1'b0 ||
        o_instr !== 16'h0 || o_instr_addr !== 16'h0 || o_pc_lock !== 1'b1 ||
        o_pc_address_en !== 1'b0) begin
      miscompares++;
      $display("FAIL %s: got req=%b addr=%h valid=%b instr=%h iaddr=%h lock=%b en=%b expected 0/0000/0/0000/0000/1/0",
               tag, o_mem_req, o_mem_addr, o_instr_valid, o_instr, o_instr_addr, o_pc_lock, o_pc_address_en);
    end
  endtask

  task automatic wait_rise(input int budget, input string tag);
    int i;
    for (i = 0; i < budget; i++) begin
      tick();
      if (rose) break;
    end
    vectors++;
    if (i == budget) begin
      miscompares++;
      $display("FAIL %s: got no request within %0d cycles expected one", tag, budget);
    end
  endtask

  task automatic test_reset();
    n_rst = 1'b0;
    #3;
    check_reset_outputs("reset_state");
    repeat (2) @(negedge clk);
    n_rst = 1'b1;
    clear_model(16'h0000);
    @(posedge clk);
    #1;
    vectors++;
    if (o_mem_req !== 1'b0) begin
      miscompares++;
      $display("FAIL early_req: got %b expected 0 after first edge", o_mem_req);
    end
  endtask

  task automatic test_basic();
    ready_rand = 0; ready_val = 1; ack_delay = 1;
    for (int i = 0; i < 60 && popped.size() < 3; i++) tick();
    vectors++;
    if (popped.size() < 3) begin
      miscompares++;
      $display("FAIL basic_timeout: got %0d pops expected 3", popped.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        vectors++;
        if (popped[i] !== 16'(i)) begin
          miscompares++;
          $display("FAIL basic_order: got %h expected %h", popped[i], 16'(i));
        end
      end
    end
  endtask

  task automatic test_fill();
    do_reset(16'h0000);
    ready_val = 0; ack_delay = 1;
    repeat (40) tick();
    #1;
    vectors++;
    if (o_mem_req !== 1'b0 || req_addrs.size() != 4 || o_instr_addr !== 16'h0000) begin
      miscompares++;
      $display("FAIL fill_stop: got req=%b nreq=%0d head=%h expected 0/4/0000",
               o_mem_req, req_addrs.size(), o_instr_addr);
    end
    ready_val = 1;
    for (int i = 0; i < 40 && (popped.size() < 4 || req_addrs.size() < 5); i++) tick();
    vectors++;
    if (popped.size() < 4 || req_addrs.size() < 5) begin
      miscompares++;
      $display("FAIL fill_timeout: got %0d pops %0d reqs expected 4/5", popped.size(), req_addrs.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        vectors++;
        if (popped[i] !== 16'(i)) begin
          miscompares++;
          $display("FAIL fill_order: got %h expected %h", popped[i], 16'(i));
        end
      end
      vectors++;
      if (req_addrs[4] !== 16'h0004) begin
        miscompares++;
        $display("FAIL fill_resume: got %h expected 0004", req_addrs[4]);
      end
    end
  endtask

  task automatic test_flush_outstanding();
    int base;
    ready_val = 1; ack_delay = 3;
    wait_rise(30, "flush_out_rise");
    tick(1'b1, 16'h0100);
    #1;
    vectors++;
    if (o_mem_req !== 1'b1 || o_pc_address_en !== 1'b0 || o_instr_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL discard_state: got req=%b en=%b valid=%b expected 1/0/0",
               o_mem_req, o_pc_address_en, o_instr_valid);
    end
    base = req_addrs.size();
    for (int i = 0; i < 30 && req_addrs.size() == base; i++) tick();
    vectors++;
    if (req_addrs.size() == base || req_addrs[req_addrs.size()-1] !== 16'h0100) begin
      miscompares++;
      $display("FAIL flush_newpc: got %0d new reqs expected first at 0100", req_addrs.size() - base);
    end
    repeat (10) tick();
  endtask

  task automatic test_flush_with_ack();
    do_reset(16'h0200);
    ready_val = 0; ack_delay = 1;
    for (int i = 0; i < 30 && q.size() < 2; i++) tick();
    wait_rise(10, "flush_ack_rise");
    tick(1'b1, 16'h0280);
    #1;
    vectors++;
    if (last_lock !== 1'b1 || o_instr_valid !== 1'b0 || o_mem_req !== 1'b0) begin
      miscompares++;
      $display("FAIL flush_ack: got lock=%b valid=%b req=%b expected 1/0/0",
               last_lock, o_instr_valid, o_mem_req);
    end
    ready_val = 1;
    wait_rise(10, "flush_ack_refetch");
    vectors++;
    if (req_addrs[req_addrs.size()-1] !== 16'h0280) begin
      miscompares++;
      $display("FAIL flush_ack_newpc: got %h expected 0280", req_addrs[req_addrs.size()-1]);
    end
    repeat (8) tick();
  endtask

  task automatic test_full_pop_ack();
    do_reset(16'h0300);
    ready_val = 0; ack_delay = 1;
    for (int i = 0; i < 60 && q.size() < QDEPTH; i++) tick();
    repeat (4) tick();
    #1;
    vectors++;
    if (o_mem_req !== 1'b0 || req_addrs.size() != 4) begin
      miscompares++;
      $display("FAIL full_idle: got req=%b nreq=%0d expected 0/4", o_mem_req, req_addrs.size());
    end
    ready_val = 1;
    tick();
    ready_val = 0;
    wait_rise(10, "full_refill_rise");
    ready_val = 1;
    tick();
    ready_val = 0;
    #1;
    vectors++;
    if (o_instr_valid !== 1'b1 || o_instr_addr !== 16'h0302) begin
      miscompares++;
      $display("FAIL pop_ack_head: got valid=%b addr=%h expected 1/0302", o_instr_valid, o_instr_addr);
    end
    repeat (20) tick();
    ready_val = 1;
    for (int i = 0; i < 40 && popped.size() < 6; i++) tick();
    vectors++;
    if (popped.size() < 6) begin
      miscompares++;
      $display("FAIL full_drain: got %0d pops expected 6", popped.size());
    end else begin
      for (int i = 0; i < 6; i++) begin
        vectors++;
        if (popped[i] !== 16'h0300 + 16'(i)) begin
          miscompares++;
          $display("FAIL full_order: got %h expected %h", popped[i], 16'h0300 + 16'(i));
        end
      end
    end
  endtask

  task automatic test_reset_mid_req();
    ready_val = 1; ack_delay = 3;
    wait_rise(20, "rst_mid_rise");
    @(negedge clk);
    #2;
    n_rst = 1'b0;
    #1;
    check_reset_outputs("reset_mid_req");
    @(negedge clk);
    n_rst = 1'b1;
    clear_model(16'h0400);
    i_flush = 1'b0;
    i_mem_ack = 1'b1;
    i_mem_data = 16'hDEAD;
    @(posedge clk);
    #1;
    vectors++;
    if (o_mem_req !== 1'b0 || o_instr_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL late_ack: got req=%b valid=%b expected 0/0", o_mem_req, o_instr_valid);
    end
    @(negedge clk);
    i_mem_ack = 1'b0;
    wait_rise(10, "rst_refetch");
    vectors++;
    if (req_addrs.size() == 0 || req_addrs[0] !== 16'h0400) begin
      miscompares++;
      $display("FAIL rst_newpc: got %0d reqs expected first at 0400", req_addrs.size());
    end
    repeat (10) tick();
  endtask

  task automatic test_random();
    ready_rand = 1; rand_delay = 1;
    for (int i = 0; i < 600; i++) tick($urandom_range(0, 24) == 0, 16'($urandom));
    ready_rand = 0; rand_delay = 0; ready_val = 1; ack_delay = 1;
    repeat (30) tick();
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish expected completion");
    $fatal(1);
  end

  initial begin
    salt = 16'($urandom);
    test_reset();
    test_basic();
    test_fill();
    test_flush_outstanding();
    test_flush_with_ack();
    test_full_pop_ack();
    test_reset_mid_req();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
